// File: rtl/drum_voice_pkg.sv
// drum_voice_pkg: shared envelope state type and widths for the drum voice
package drum_voice_pkg;
  typedef enum logic [1:0] {IDLE, ATTACK, DECAY} env_state_t;
  localparam int SAMPLE_W = 24;
  localparam int LEVEL_W = 8;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;
endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: free-running divider, one-cycle tick every DIV clocks
module sample_tick_gen #(
  parameter int DIV = 1042
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = cnt == 16'(DIV - 1);
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 16'd1;
endmodule

// File: rtl/drum_env_voice.sv
// drum_env_voice: attack/decay enveloped sample stream to the codec write port
// Optional DROP_CNT_EN adds a saturating overrun counter on drop_count.
module drum_env_voice
  import drum_voice_pkg::*;
#(
  parameter int SAMPLE_DIV = 1042,
  parameter int ATTACK_INC = 32,
  parameter int DECAY_DIV  = 19
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                trigger,
  input  logic [SAMPLE_W-1:0] wave_in,
  input  logic                write_ready,
  output logic                write,
  output logic [SAMPLE_W-1:0] writedata_left,
  output logic [SAMPLE_W-1:0] writedata_right,
  output logic                active
`ifdef DROP_CNT_EN
  ,
  output logic [15:0]         drop_count
`endif
);
  env_state_t state, state_n, st_eff;
  logic [LEVEL_W-1:0] level, level_n, sub, sub_n, sub_eff, att_sat;
  logic [LEVEL_W:0] att_sum;
  logic trig_q, trig_rise, tick;
  logic signed [SAMPLE_W-1:0] s;
  logic signed [32:0] p;
  sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .tick(tick)
  );
  assign trig_rise = trigger & ~trig_q;
  assign active = state != IDLE;
  assign writedata_right = writedata_left;
  assign s = {~wave_in[SAMPLE_W-1], wave_in[SAMPLE_W-2:0]};
  assign p = 33'(s) * 33'($signed({1'b0, level}));
  // a retrigger takes effect before the envelope update of a coincident tick
  always_comb begin
    st_eff = trig_rise ? ATTACK : state;
    sub_eff = trig_rise ? '0 : sub;
    state_n = st_eff;
    sub_n = sub_eff;
    level_n = level;
    att_sum = {1'b0, level} + 9'(ATTACK_INC);
    att_sat = att_sum[LEVEL_W] ? LEVEL_MAX : att_sum[LEVEL_W-1:0];
    if (tick)
      case (st_eff)
        IDLE: level_n = '0;
        ATTACK: begin
          level_n = att_sat;
          state_n = att_sat == LEVEL_MAX ? DECAY : ATTACK;
        end
        DECAY:
          if (sub_eff == 8'(DECAY_DIV - 1)) begin
            sub_n = '0;
            level_n = level - 8'd1;
            state_n = level_n == '0 ? IDLE : DECAY;
          end else sub_n = sub_eff + 8'd1;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state <= IDLE;
      level <= '0;
      sub <= '0;
      trig_q <= 1'b0;
    end else begin
      state <= state_n;
      level <= level_n;
      sub <= sub_n;
      trig_q <= trigger;
    end
  // an unaccepted sample is overwritten by the next tick and write stays high
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      write <= 1'b0;
      writedata_left <= '0;
    end else begin
      write <= tick | (write & ~write_ready);
      if (tick) writedata_left <= 24'(p >>> 8);
    end
`ifdef DROP_CNT_EN
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) drop_count <= '0;
    else if (tick && write && !write_ready && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
endmodule

// File: doc/drum_env_voice.md
Name: drum_env_voice

Overview:
Downstream stage of the sawtooth oscillator. It takes the free-running 24-bit unsigned waveform and samples it at audio rate (about 48 kHz). On each sequencer trigger it shapes the waveform with a linear attack/decay amplitude envelope, then writes the signed result to the audio codec's left/right write port using a write/write_ready handshake.

Parameters:
SAMPLE_DIV, 1042, CLOCK_50 cycles per audio sample tick (50 MHz / 1042 ≈ 48 kHz); legal range 2..65535.
ATTACK_INC, 32, envelope increment per sample tick during ATTACK (1..255).
DECAY_DIV, 19, sample ticks per 1-step envelope decrement during DECAY (1..255).

Ports:
CLOCK_50  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-high reset.
trigger  input  1  sequencer step hit; rising edge starts or restarts the envelope.
wave_in  input  24  unsigned offset-binary waveform from the oscillator.
write_ready  input  1  codec can accept a sample this cycle.
write  output  1  sample pending; a transfer occurs in any cycle where write && write_ready.
writedata_left  output  24  signed two's-complement sample.
writedata_right  output  24  identical to writedata_left.
active  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, active-high): the following take these values immediately and hold them while reset is high.
  - write=0, writedata_left/right=0, active=0.
  - state=IDLE, level=0, tick counter=0, decay sub-counter=0, trigger edge register=0.
- Tick generator:
  - The counter runs 0..SAMPLE_DIV-1 and wraps.
  - tick=1 for exactly one cycle when the counter is at SAMPLE_DIV-1.
  - It runs continuously, independent of state.
- Trigger edge detect: trig_rise = trigger & ~trigger_q. A level held high does not retrigger.
- Envelope level: 8-bit unsigned, 0..255.
- FSM states and transitions:
  - IDLE: level=0. On trig_rise, go to ATTACK.
  - ATTACK: on each tick, level = min(level+ATTACK_INC, 255), computed in 9 bits then saturated. When the saturated result is 255, go to DECAY on the same tick.
  - DECAY: on each tick, the sub-counter increments. When it reaches DECAY_DIV-1 it clears and level decrements by 1. When level reaches 0, go to IDLE.
- Retrigger: trig_rise in ATTACK or DECAY goes to ATTACK and keeps the current level, so there is no step discontinuity. The sub-counter clears.
- trig_rise and tick in the same cycle: the state change takes effect first. The envelope update on that tick uses the new state, i.e. an ATTACK increment.
- Sample arithmetic, evaluated on the tick cycle:
  - s = {~wave_in[23], wave_in[22:0]} as signed 24-bit.
  - p = s * $signed({1'b0, level}), 33-bit signed.
  - y = p >>> 8, truncated to 24 bits.
  - The level used is the pre-update registered value.
- Output register:
  - On the tick cycle, y is loaded into writedata_left/right.
  - write is set on the following edge, so write is high one cycle after the tick cycle.
- Handshake:
  - write stays high and the data stays stable until the cycle where write_ready=1. On that edge write clears, unless a tick loads a new sample in the same cycle, in which case write stays high.
  - Overrun (tick while write is high and not accepted): the data is overwritten with the new y and write stays 1.
- In IDLE, samples are still produced with level=0, so y=0 and the codec stream stays continuous.
- Reset mid-envelope: everything returns immediately to the reset values above; any pending write is abandoned.

Optional Feature:
Macro DROP_CNT_EN.
- Defined: adds output port drop_count [15:0], reset value 0. It increments (saturating at 16'hFFFF) on every overrun cycle, i.e. tick && write && !write_ready.
- Undefined: the port and counter are absent; overrun behaviour is otherwise identical.

Decomposition:
- Package drum_voice_pkg holds:
  - the env_state_t enum {IDLE, ATTACK, DECAY};
  - LEVEL_MAX=8'd255;
  - SAMPLE_W=24;
  - LEVEL_W=8.
- Sub-module sample_tick_gen (parameter DIV; ports CLOCK_50, reset, tick) contains the divider counter.
- Envelope FSM, multiply and handshake stay in drum_env_voice.

Test Plan:
Bench parameters for all scenarios: SAMPLE_DIV=4, ATTACK_INC=64, DECAY_DIV=1; write_ready tied 1 unless stated otherwise.
1. Reset held, then released; no trigger -> write pulses for 1 cycle every 4 cycles with data 0; active=0; level=0.
2. Single trigger pulse -> level sequence over ticks is 64, 128, 192, 255; DECAY is entered on the 4th tick; level then falls 254 → 0 over the next 255 ticks; IDLE and active=0 follow.
3. wave_in held constant, level 255 -> check the sample loaded on the tick after the level reaches 255:
   - wave_in=24'hFFFFFF -> writedata=24'h7F7FFF;
   - wave_in=24'h000000 -> writedata=24'h808000;
   - wave_in=24'h800000 -> writedata=0.
4. Retrigger when level=100 in DECAY -> next tick gives level=164 (ATTACK, no drop to 0); trigger held high for 20 cycles causes no further retrigger.
5. write_ready=0 for 10 cycles -> write stays 1; data equals the last tick's sample; 2 overruns occur (drop_count=2 with DROP_CNT_EN). Raising write_ready -> write clears next edge.
6. Assert reset mid-ATTACK with write pending -> write, writedata, active and level are 0 in the same cycle, before the next clock edge.
